// File: rtl/row_matrix_reader.sv
// row_matrix_reader: credit-flow read sequencer for a row_matrix, re-emitting rows as a valid/ready stream.
// A read is issued only when a FIFO slot is guaranteed free, because the memory cannot stall.
module row_matrix_reader #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 5,
  parameter int SCALAR_BITS = 32,
  parameter int MEMORY_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ROW_ADDR_WIDTH = $clog2(NUM_ROWS),
  localparam int ROW_SIZE = NUM_COLS * SCALAR_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_ADDR_WIDTH-1:0] start_row,
  input  logic [ROW_ADDR_WIDTH-1:0] end_row,
  output logic                      busy,
  output logic                      done,
  output logic                      range_err,
  output logic [ROW_ADDR_WIDTH-1:0] mem_row_addr,
  output logic                      mem_row_addr_ready,
  input  logic                      mem_row_valid,
  input  logic [ROW_SIZE-1:0]       mem_row_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROW_SIZE-1:0]       out_data,
  output logic [ROW_ADDR_WIDTH-1:0] out_row_idx,
  output logic                      out_last
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;

  if (FIFO_DEPTH < MEMORY_LATENCY + 1) begin : g_depth_check
    $error("row_matrix_reader: FIFO_DEPTH must be >= MEMORY_LATENCY+1");
  end

  logic [1:0]                state;
  logic [ROW_ADDR_WIDTH-1:0] last_row, next_addr, out_idx;
  logic [CW-1:0]             occ, inflight;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [ROW_SIZE-1:0]       fifo [FIFO_DEPTH];
  logic                      idle, start_ok, issue, wr, pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign idle      = state == IDLE;
  assign start_ok  = start && idle && start_row <= end_row && 32'(end_row) < NUM_ROWS;
  assign out_valid = occ != '0;
  assign pop       = out_valid && out_ready;
  // occupancy + in-flight is the committed slot count; a pop this cycle frees one immediately
  assign issue     = state == ISSUE &&
                     (({1'b0, occ} + {1'b0, inflight} < (CW + 1)'(FIFO_DEPTH)) || pop);
  // responses with nothing outstanding are leftovers from before a reset
  assign wr        = mem_row_valid && inflight != '0;

  assign busy               = !idle;
  assign mem_row_addr       = next_addr;
  assign mem_row_addr_ready = issue;
  assign out_data           = out_valid ? fifo[rd_ptr] : '0;
  assign out_row_idx        = out_idx;
  assign out_last           = out_valid && out_idx == last_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_row  <= '0;
      next_addr <= '0;
      out_idx   <= '0;
      occ       <= '0;
      inflight  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      done      <= pop && out_last;
      range_err <= start && idle && !start_ok;
      if (start_ok) begin
        state     <= ISSUE;
        last_row  <= end_row;
        next_addr <= start_row;
        out_idx   <= start_row;
      end else if (issue && next_addr == last_row) begin
        state <= DRAIN;
      end else if (pop && out_last) begin
        state <= IDLE;
      end
      if (issue && next_addr != last_row) next_addr <= next_addr + 1'b1;
      if (pop) begin
        out_idx <= out_idx + 1'b1;
        rd_ptr  <= inc_ptr(rd_ptr);
      end
      if (wr) wr_ptr <= inc_ptr(wr_ptr);
      occ      <= occ + CW'(wr) - CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(wr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) fifo[wr_ptr] <= mem_row_in;
  end
endmodule

// File: tb/tb_row_matrix_reader.sv
// tb_row_matrix_reader: scoreboard bench for row_matrix_reader with behavioural row memories.
// Default instance covers sweeps, backpressure, errors and reset; a 3-deep instance covers credit stalls.
module tb_row_matrix_reader;
  localparam int NR = 3, RS = 160;

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic          start, busy, done, range_err, mrar, mrv, ov, ordy, olast;
  logic [1:0]    start_row, end_row, mra, oidx;
  logic [RS-1:0] mri, od;
  logic          start1, busy1, done1, err1, mrar1, mrv1, ov1, ordy1, olast1;
  logic [2:0]    sr1, er1, mra1, oidx1;
  logic [RS-1:0] mri1, od1;

  row_matrix_reader dut (
    .clk(clk), .rst(rst), .start(start), .start_row(start_row), .end_row(end_row),
    .busy(busy), .done(done), .range_err(range_err), .mem_row_addr(mra),
    .mem_row_addr_ready(mrar), .mem_row_valid(mrv), .mem_row_in(mri),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_row_idx(oidx), .out_last(olast)
  );

  row_matrix_reader #(.NUM_ROWS(8), .FIFO_DEPTH(3), .MEMORY_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .start_row(sr1), .end_row(er1),
    .busy(busy1), .done(done1), .range_err(err1), .mem_row_addr(mra1),
    .mem_row_addr_ready(mrar1), .mem_row_valid(mrv1), .mem_row_in(mri1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_row_idx(oidx1), .out_last(olast1)
  );

  function automatic logic [RS-1:0] rowdata(input int a);
    logic [RS-1:0] d;
    for (int c = 0; c < 5; c++) d[c*32 +: 32] = 32'hC0DE0000 ^ 32'(a * 16 + c);
    return d;
  endfunction

  // two-cycle read latency memories that ignore the reader's reset
  logic [1:0] vp = '0, vp1 = '0;
  int ap [2], ap1 [2];
  always @(posedge clk) begin
    vp <= {vp[0], mrar};   ap[1]  <= ap[0];  ap[0]  <= int'(mra);
    vp1 <= {vp1[0], mrar1}; ap1[1] <= ap1[0]; ap1[0] <= int'(mra1);
  end
  assign mrv = vp[1];   assign mri = rowdata(ap[1]);
  assign mrv1 = vp1[1]; assign mri1 = rowdata(ap1[1]);

  int checks = 0, passed = 0;
  task automatic chk(input string tag, input logic [RS-1:0] got, input logic [RS-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  typedef struct { int idx; logic last; } exp_t;
  exp_t q[$];
  int cyc = 0, start_cyc = 0, exp_issue = 0, issue_cnt = 0, outstanding = 0;
  int first_issue = 0, first_valid = -1, done_at = 0, done_cnt = 0, err_cnt = 0;
  int issue1 = 0, exp1 = 0, done1_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst) begin
    if (mrar) begin
      chk("issue_addr", RS'(mra), RS'(exp_issue));
      if (issue_cnt == 0) first_issue = cyc;
      exp_issue++; issue_cnt++; outstanding++;
      chk("no_overflow", RS'(outstanding <= 4), 1);
    end
    if (ov) begin
      if (q.size() == 0) chk("spurious_out", RS'(ov), 0);
      else begin
        chk("out_idx", RS'(oidx), RS'(q[0].idx));
        chk("out_data", od, rowdata(q[0].idx));
        chk("out_last", RS'(olast), RS'(q[0].last));
        if (first_valid < 0) first_valid = cyc;
        if (ordy) begin void'(q.pop_front()); outstanding--; end
      end
    end
    if (done) begin done_cnt++; done_at = cyc; end
    if (range_err) err_cnt++;
  end

  always @(negedge clk) if (rst) begin
    if (mrar1) issue1++;
    if (ov1 && ordy1) begin
      chk("u1_idx", RS'(oidx1), RS'(exp1));
      chk("u1_data", od1, rowdata(exp1));
      chk("u1_last", RS'(olast1), RS'(exp1 == 7));
      exp1++;
    end
    if (done1) done1_cnt++;
  end

  task automatic do_start(input int s, input int e);
    start_row = 2'(s); end_row = 2'(e); start = 1;
    start_cyc = cyc; issue_cnt = 0; first_valid = -1; exp_issue = s;
    if (s <= e && e < NR) for (int i = s; i <= e; i++) q.push_back('{i, i == e});
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    for (int n = 0; n < 100 && done_cnt == d0; n++) @(negedge clk);
    chk({tag, "_done"}, RS'(done_cnt), RS'(d0 + 1));
    chk({tag, "_drained"}, RS'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, RS'(busy), 0);     chk({tag, "_done"}, RS'(done), 0);
    chk({tag, "_err"}, RS'(range_err), 0); chk({tag, "_mrar"}, RS'(mrar), 0);
    chk({tag, "_addr"}, RS'(mra), 0);      chk({tag, "_valid"}, RS'(ov), 0);
    chk({tag, "_data"}, od, 0);            chk({tag, "_idx"}, RS'(oidx), 0);
    chk({tag, "_last"}, RS'(olast), 0);
  endtask

  initial begin
    #100000 $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e0, d0;
    start = 0; start_row = 0; end_row = 0; ordy = 1;
    start1 = 0; sr1 = 0; er1 = 0; ordy1 = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1;
    @(posedge clk); #1;

    do_start(0, 2);
    wait_done("full");
    chk("full_first_issue", RS'(first_issue - start_cyc), 1);
    chk("full_first_valid", RS'(first_valid - start_cyc), 4);
    chk("full_done_cycle", RS'(done_at - start_cyc), 7);
    chk("full_issues", RS'(issue_cnt), 3);
    chk("full_idle", RS'(busy), 0);

    ordy = 0;
    do_start(0, 2);
    while (cyc - start_cyc < 12) @(posedge clk);
    #1 chk("bp_issues", RS'(issue_cnt), 3);
    chk("bp_valid_held", RS'(ov), 1);
    chk("bp_first_valid", RS'(first_valid - start_cyc), 4);
    ordy = 1;
    wait_done("bp");

    do_start(1, 1);
    wait_done("single");
    chk("single_issues", RS'(issue_cnt), 1);

    e0 = err_cnt;
    do_start(2, 1);
    repeat (4) @(posedge clk);
    #1 chk("err_order_pulse", RS'(err_cnt), RS'(e0 + 1));
    chk("err_order_busy", RS'(busy), 0);
    chk("err_order_issues", RS'(issue_cnt), 0);
    do_start(0, 3);
    repeat (4) @(posedge clk);
    #1 chk("err_bound_pulse", RS'(err_cnt), RS'(e0 + 2));
    chk("err_bound_issues", RS'(issue_cnt), 0);

    d0 = done_cnt;
    do_start(0, 2);
    @(posedge clk); #1;
    rst = 0; q.delete(); outstanding = 0;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rst = 1;
    repeat (6) @(posedge clk);
    #1 chk("midrst_stale_dropped", RS'(ov), 0);
    chk("midrst_no_done", RS'(done_cnt), RS'(d0));
    do_start(0, 2);
    wait_done("after_rst");
    chk("after_rst_issues", RS'(issue_cnt), 3);

    e0 = err_cnt;
    do_start(0, 2);
    start_row = 1; end_row = 1; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done("busy_start");
    chk("busy_start_issues", RS'(issue_cnt), 3);
    chk("busy_start_no_err", RS'(err_cnt), RS'(e0));
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    #1 chk("busy_start_no_rerun", RS'(done_cnt), RS'(d0));
    chk("busy_start_idle", RS'(busy), 0);

    sr1 = 0; er1 = 7; start1 = 1;
    @(posedge clk); #1 start1 = 0;
    repeat (12) @(posedge clk);
    #1 chk("stall_issues", RS'(issue1), 3);
    chk("stall_ready_low", RS'(mrar1), 0);
    chk("stall_valid", RS'(ov1), 1);
    for (int k = 1; k <= 3; k++) begin
      ordy1 = 1;
      @(posedge clk); #1 ordy1 = 0;
      repeat (4) @(posedge clk);
      #1 chk("stall_resume", RS'(issue1), RS'(3 + k));
    end
    ordy1 = 1;
    for (int n = 0; n < 100 && done1_cnt == 0; n++) @(negedge clk);
    chk("stall_done", RS'(done1_cnt), 1);
    chk("stall_rows", RS'(exp1), 8);
    chk("stall_total_issues", RS'(issue1), 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
